// File: rtl/clk_div_prog_pkg.sv
// Shared constants for the programmable clock divider: default widths and
// divisor values for the common board rates derived from 100 MHz.
package clk_div_prog_pkg;

    localparam int CNT_W_DEF       = 17;
    localparam int DEFAULT_DIV_DEF = 99_999;
    localparam int CH_IDX_W        = 4;

    // Half-period divisors: f_out = 100 MHz / (2 * (div + 1))
    localparam int DIV_500HZ = 99_999;
    localparam int DIV_1KHZ  = 49_999;
    localparam int DIV_1HZ   = 49_999_999;  // needs CNT_W >= 26

    function automatic int div_for_hz(input int f_clk_hz, input int f_out_hz);
        return f_clk_hz / (2 * f_out_hz) - 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/pending divisor pair and
// the output toggle flop. Pending divisors are only adopted at terminal count.
module clk_div_chan
    import clk_div_prog_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] div_act_reg, div_act_next;
    logic [CNT_W-1:0] div_pend_reg, div_pend_next;
    logic             pend_reg, pend_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
    logic             terminal;

    assign terminal = (cnt_reg == div_act_reg);

    always_comb begin
        cnt_next      = cnt_reg;
        div_act_next  = div_act_reg;
        div_pend_next = div_pend_reg;
        pend_next     = pend_reg;
        clk_out_next  = clk_out_reg;
        tick_next     = 1'b0;

        if (!en) begin
            cnt_next     = '0;
            clk_out_next = 1'b0;
            if (pend_reg) begin
                div_act_next = div_pend_reg;
                pend_next    = 1'b0;
            end
        end else if (terminal) begin
            cnt_next     = '0;
            clk_out_next = ~clk_out_reg;
            tick_next    = 1'b1;
            if (pend_reg) begin
                div_act_next = div_pend_reg;
                pend_next    = 1'b0;
            end
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        // A write on the terminal edge lands after the old pending value was taken
        if (wr) begin
            div_pend_next = wr_div;
            pend_next     = 1'b1;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            div_act_reg  <= DIV_RST;
            div_pend_reg <= DIV_RST;
            pend_reg     <= 1'b0;
            clk_out_reg  <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            div_act_reg  <= div_act_next;
            div_pend_reg <= div_pend_next;
            pend_reg     <= pend_next;
            clk_out_reg  <= clk_out_next;
            tick_reg     <= tick_next;
        end
    end

    assign clk_out = clk_out_reg;
    assign tick    = tick_reg;
    assign pend    = pend_reg;

endmodule

// File: rtl/clk_div_prog.sv
// Multi-channel programmable clock divider: NCH independent channels plus the
// configuration write decode. Out-of-range channel indices match no channel.
module clk_div_prog
    import clk_div_prog_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                clk_100M,
    input  logic                rst_n,
    input  logic [NCH-1:0]      ch_en,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [NCH-1:0]      clk_out,
    output logic [NCH-1:0]      tick,
    output logic [NCH-1:0]      pend
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            logic wr_sel;
            assign wr_sel = cfg_we && (cfg_ch == CH_IDX_W'(gi));

            clk_div_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk_100M (clk_100M),
                .rst_n    (rst_n),
                .en       (ch_en[gi]),
                .wr       (wr_sel),
                .wr_div   (cfg_div),
                .clk_out  (clk_out[gi]),
                .tick     (tick[gi]),
                .pend     (pend[gi])
            );
        end
    endgenerate

endmodule
